alu_issue_stage: RTL



---
 rtl/alu_issue_stage.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// Operand issue and result capture stage around the 32-bit combinational ALU.
// Requests (a, b, op) are accepted through a valid/ready handshake into a
// small circular FIFO. The head entry drives the ALU directly, and the ALU
// result is captured into a one-entry output register that has its own
// valid/ready handshake. Sustains one operation per cycle under backpressure.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req_valid  request present            req_ready  FIFO can accept
//   req_a/b    32-bit operands            req_op     3-bit ALU opcode
//   alu_a/b    head operands to alu32     alu_op     head opcode to alu32
//   alu_s      alu32 result               alu_c_out  alu32 carry
//   rsp_valid  result register full       rsp_ready  consumer accepts result
//   rsp_s      registered result          rsp_c_out  registered carry
//   rsp_zero   registered (rsp_s == 0)    rsp_op     opcode of the result
//   retired    16-bit count of result handshakes, wraps modulo 2^16
module alu_issue_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [2:0]  req_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_s,
  input  logic        alu_c_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_s,
  output logic        rsp_c_out,
  output logic        rsp_zero,
  output logic [2:0]  rsp_op,
  output logic [15:0] retired
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Request storage (data only, no reset needed)
  logic [31:0]      r_mem_a  [DEPTH];
  logic [31:0]      r_mem_b  [DEPTH];
  logic [2:0]       r_mem_op [DEPTH];

  // FIFO control
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Result register
  logic             r_vld_p1;
  logic [31:0]      r_s_p1;
  logic             r_c_p1;
  logic             r_zero_p1;
  logic [2:0]       r_op_p1;
  logic [15:0]      r_retired;

  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_rsp_free;
  logic             w_drain;

  // ready depends only on registered state, never on a same-cycle pop
  assign req_ready  = (r_count != FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_push     = req_valid & req_ready;
  assign w_rsp_free = ~r_vld_p1 | rsp_ready;
  // Capture and pop are the same event: the head is consumed when the result
  // register can take the ALU output.
  assign w_pop      = ~w_empty & w_rsp_free;
  assign w_drain    = r_vld_p1 & rsp_ready;

  // ---- Stage p0: FIFO write, head drives the ALU ----
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]  <= req_a;
      r_mem_b[r_wr_ptr]  <= req_b;
      r_mem_op[r_wr_ptr] <= req_op;
    end
  end

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (!w_empty) begin
      alu_a  = r_mem_a[r_rd_ptr];
      alu_b  = r_mem_b[r_rd_ptr];
      alu_op = r_mem_op[r_rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---- Stage p1: result register and retire counter ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p1  <= 1'b0;
      r_s_p1    <= '0;
      r_c_p1    <= 1'b0;
      r_zero_p1 <= 1'b0;
      r_op_p1   <= '0;
      r_retired <= '0;
    end else begin
      if (w_pop) begin
        r_vld_p1  <= 1'b1;
        r_s_p1    <= alu_s;
        r_c_p1    <= alu_c_out;
        r_zero_p1 <= (alu_s == 32'd0);
        r_op_p1   <= alu_op;
      end else if (w_drain) begin
        r_vld_p1  <= 1'b0;
      end
      if (w_drain) r_retired <= r_retired + 16'd1;
    end
  end

  assign rsp_valid = r_vld_p1;
  assign rsp_s     = r_s_p1;
  assign rsp_c_out = r_c_p1;
  assign rsp_zero  = r_zero_p1;
  assign rsp_op    = r_op_p1;
  assign retired   = r_retired;

endmodule
